// File: rtl/ped_request_scheduler_pkg.sv
// Shared definitions for the pedestrian request scheduler: FSM state codes,
// side codes and a constant-to-BCD helper used for the walk-time loads.
package ped_request_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARB     = 3'd1,
    REQ     = 3'd2,
    WALKING = 3'd3,
    RELEASE = 3'd4,
    GAP     = 3'd5
  } state_t;

  localparam logic SIDE_M = 1'b0;
  localparam logic SIDE_C = 1'b1;

  // Two-digit BCD of a constant in 0..99.
  function automatic logic [7:0] to_bcd(input int value);
    return {4'(value / 10), 4'(value % 10)};
  endfunction

endpackage

// File: rtl/ped_request_scheduler_btn_debounce.sv
// Button conditioner: 2-flop synchroniser followed by a stability counter that
// only accepts a new level after it has held for DB_CYCLES clocks.
module btn_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic IN,
  output logic OUT
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_out;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_out   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= IN;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_out) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
        r_out <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign OUT = r_out;

endmodule

// File: rtl/ped_request_scheduler.sv
// Pedestrian request scheduler: latches button requests, grants them round-robin
// to the sequencer and counts the walk down in BCD. ACK_TIMEOUT_EN adds an ack watchdog.
module ped_request_scheduler
  import ped_request_scheduler_pkg::*;
#(
  parameter int DB_CYCLES      = 16,
  parameter int WALK_TIME      = 20,
  parameter int WALK_TIME_BUSY = 10,
  parameter int GAP_TIME       = 5
`ifdef ACK_TIMEOUT_EN
  ,
  parameter int ACK_TIMEOUT    = 8
`endif
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK,
  input  logic       PQM_BTN,
  input  logic       PQC_BTN,
  input  logic       BUSY,
  input  logic       SEQ_READY,
  input  logic       SEQ_ACK,
  output logic       GNT_M,
  output logic       GNT_C,
  output logic       WALK,
  output logic [3:0] WALK_H,
  output logic [3:0] WALK_L,
  output logic       PEND_M,
  output logic       PEND_C,
  output logic       FAULT
);

  localparam logic [7:0] WALK_BCD      = to_bcd(WALK_TIME);
  localparam logic [7:0] WALK_BUSY_BCD = to_bcd(WALK_TIME_BUSY);

  state_t     r_state, w_state_next;
  logic       w_db_m, w_db_c, r_db_m_d, r_db_c_d;
  logic       w_rise_m, w_rise_c;
  logic       r_pend_m, r_pend_c;
  logic       r_side, r_last, w_arb_side;
  logic       w_active, w_serving_m, w_serving_c;
  logic       w_walk_last, w_timeout, w_release_done;
  logic [5:0] r_gap;
  logic [3:0] r_walk_h, r_walk_l;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_m (.CLK(CLK), .RST(RST), .IN(PQM_BTN), .OUT(w_db_m));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_c (.CLK(CLK), .RST(RST), .IN(PQC_BTN), .OUT(w_db_c));

  assign w_rise_m = w_db_m & ~r_db_m_d;
  assign w_rise_c = w_db_c & ~r_db_c_d;

  assign w_arb_side = (r_pend_m && r_pend_c) ? ~r_last : (r_pend_m ? SIDE_M : SIDE_C);
  assign w_active   = (r_state == REQ) || (r_state == WALKING) || (r_state == RELEASE);

  // The side under service ignores its own button from ARB until it is released.
  assign w_serving_m = ((r_state == ARB) && (w_arb_side == SIDE_M)) || (w_active && (r_side == SIDE_M));
  assign w_serving_c = ((r_state == ARB) && (w_arb_side == SIDE_C)) || (w_active && (r_side == SIDE_C));

  assign w_walk_last    = (r_state == WALKING) && TICK && (r_walk_h == 4'd0) && (r_walk_l == 4'd1);
  assign w_release_done = (r_state == RELEASE) && (SEQ_ACK || w_timeout);

`ifdef ACK_TIMEOUT_EN
  logic [7:0] r_to_cnt;
  logic       r_fault;

  assign w_timeout = (r_state == RELEASE) && TICK && !SEQ_ACK && (r_to_cnt == 8'(ACK_TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_to_cnt <= 8'd0;
      r_fault  <= 1'b0;
    end else begin
      if (r_state != RELEASE) r_to_cnt <= 8'd0;
      else if (TICK)          r_to_cnt <= r_to_cnt + 8'd1;
      if (w_timeout) r_fault <= 1'b1;
    end
  end

  assign FAULT = r_fault;
`else
  assign w_timeout = 1'b0;
  assign FAULT     = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if ((r_pend_m || r_pend_c) && (r_gap == 6'd0)) w_state_next = ARB;
      ARB:     w_state_next = REQ;
      REQ:     if (SEQ_READY) w_state_next = WALKING;
      WALKING: if (w_walk_last) w_state_next = RELEASE;
      RELEASE: if (w_release_done) w_state_next = (GAP_TIME == 0) ? IDLE : GAP;
      GAP:     if (r_gap == 6'd0) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_db_m_d <= 1'b0;
      r_db_c_d <= 1'b0;
      r_pend_m <= 1'b0;
      r_pend_c <= 1'b0;
      r_side   <= SIDE_M;
      r_last   <= SIDE_C;
      r_gap    <= 6'd0;
      r_walk_h <= 4'd0;
      r_walk_l <= 4'd0;
    end else begin
      r_db_m_d <= w_db_m;
      r_db_c_d <= w_db_c;
      if (r_state == ARB) r_side <= w_arb_side;

      if (w_release_done && (r_side == SIDE_M)) r_pend_m <= 1'b0;
      else if (w_rise_m && !w_serving_m)        r_pend_m <= 1'b1;
      if (w_release_done && (r_side == SIDE_C)) r_pend_c <= 1'b0;
      else if (w_rise_c && !w_serving_c)        r_pend_c <= 1'b1;

      if (w_release_done) begin
        r_last <= r_side;
        r_gap  <= 6'(GAP_TIME);
      end else if ((r_state == GAP) && TICK && (r_gap != 6'd0)) begin
        r_gap <= r_gap - 6'd1;
      end

      // BCD countdown: a units digit of 0 wraps to 9 and borrows from the tens.
      if ((r_state == REQ) && SEQ_READY) begin
        {r_walk_h, r_walk_l} <= BUSY ? WALK_BUSY_BCD : WALK_BCD;
      end else if (r_state != WALKING) begin
        r_walk_h <= 4'd0;
        r_walk_l <= 4'd0;
      end else if (TICK) begin
        if (r_walk_l == 4'd0) begin
          r_walk_l <= 4'd9;
          r_walk_h <= r_walk_h - 4'd1;
        end else begin
          r_walk_l <= r_walk_l - 4'd1;
        end
      end
    end
  end

  assign GNT_M  = w_active && (r_side == SIDE_M);
  assign GNT_C  = w_active && (r_side == SIDE_C);
  assign WALK   = (r_state == WALKING);
  assign WALK_H = r_walk_h;
  assign WALK_L = r_walk_l;
  assign PEND_M = r_pend_m;
  assign PEND_C = r_pend_c;

endmodule

// File: tb/tb_ped_request_scheduler.sv
// Directed bench for ped_request_scheduler: walk grants are checked by a
// scoreboard monitor, everything else by inline directed checks.
module tb_ped_request_scheduler;

  logic       CLK = 1'b0;
  logic       RST, TICK, PQM_BTN, PQC_BTN, BUSY, SEQ_READY, SEQ_ACK;
  logic       GNT_M, GNT_C, WALK, PEND_M, PEND_C, FAULT;
  logic [3:0] WALK_H, WALK_L;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       side;
    logic [3:0] h;
    logic [3:0] l;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic mon_prev_walk = 1'b0;

  always #5 CLK = ~CLK;

  ped_request_scheduler dut (
    .CLK(CLK), .RST(RST), .TICK(TICK), .PQM_BTN(PQM_BTN), .PQC_BTN(PQC_BTN),
    .BUSY(BUSY), .SEQ_READY(SEQ_READY), .SEQ_ACK(SEQ_ACK),
    .GNT_M(GNT_M), .GNT_C(GNT_C), .WALK(WALK), .WALK_H(WALK_H), .WALK_L(WALK_L),
    .PEND_M(PEND_M), .PEND_C(PEND_C), .FAULT(FAULT)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic tick();
    TICK = 1'b1;
    cycles(1);
    TICK = 1'b0;
    cycles(1);
  endtask

  task automatic press(input logic m, input logic c, input int n);
    PQM_BTN = m;
    PQC_BTN = c;
    cycles(n);
    PQM_BTN = 1'b0;
    PQC_BTN = 1'b0;
  endtask

  task automatic ready_pulse(input logic busy, input logic side, input logic [3:0] h, input logic [3:0] l);
    exp_t e;
    e.side = side;
    e.h    = h;
    e.l    = l;
    exp_q.push_back(e);
    BUSY      = busy;
    SEQ_READY = 1'b1;
    cycles(1);
    SEQ_READY = 1'b0;
    BUSY      = 1'b0;
  endtask

  task automatic ack_pulse();
    SEQ_ACK = 1'b1;
    cycles(1);
    SEQ_ACK = 1'b0;
  endtask

  // Monitor: every walk start is matched against the next expected grant.
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      chk("gnt_exclusive", {31'd0, GNT_M & GNT_C}, 0);
      if (WALK && !mon_prev_walk) begin
        if (exp_q.size() == 0) begin
          chk("walk_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          $display("walk start: gnt_m=%0b gnt_c=%0b count=%0d%0d", GNT_M, GNT_C, WALK_H, WALK_L);
          chk("walk_side", {GNT_M, GNT_C}, mon_e.side ? 2'b01 : 2'b10);
          chk("walk_load", {WALK_H, WALK_L}, {mon_e.h, mon_e.l});
        end
      end
      mon_prev_walk = WALK;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; TICK = 1'b0; PQM_BTN = 1'b0; PQC_BTN = 1'b0;
    BUSY = 1'b0; SEQ_READY = 1'b0; SEQ_ACK = 1'b0;
    cycles(3);
    chk("reset_outputs", {GNT_M, GNT_C, WALK, PEND_M, PEND_C, FAULT, WALK_H, WALK_L}, 0);
    RST = 1'b0;
    cycles(2);

    // 1: single main request, full walk, ack, gap
    press(1'b1, 1'b0, 40);
    chk("t1_pend_m", PEND_M, 1);
    chk("t1_gnt_m_req", GNT_M, 1);
    chk("t1_walk_in_req", WALK, 0);
    chk("t1_count_in_req", {WALK_H, WALK_L}, 0);
    ready_pulse(1'b0, 1'b0, 4'd2, 4'd0);
    repeat (10) tick();
    chk("t1_count_10", {WALK_H, WALK_L}, 8'h10);
    tick();
    chk("t1_count_09", {WALK_H, WALK_L}, 8'h09);
    repeat (8) tick();
    chk("t1_count_01", {WALK_H, WALK_L}, 8'h01);
    chk("t1_walk_on", WALK, 1);
    tick();
    chk("t1_walk_off", WALK, 0);
    chk("t1_count_00", {WALK_H, WALK_L}, 0);
    cycles(5);
    chk("t1_gnt_held_release", GNT_M, 1);
    ack_pulse();
    chk("t1_gnt_m_dropped", GNT_M, 0);
    chk("t1_pend_m_cleared", PEND_M, 0);
    repeat (5) tick();
    cycles(4);
    chk("t1_idle_no_grant", {GNT_M, GNT_C}, 0);

    // 2: simultaneous presses after reset, main first then country after gap
    RST = 1'b1;
    cycles(1);
    RST = 1'b0;
    cycles(1);
    press(1'b1, 1'b1, 40);
    chk("t2_pend_both", {PEND_M, PEND_C}, 2'b11);
    chk("t2_main_wins", {GNT_M, GNT_C}, 2'b10);
    ready_pulse(1'b0, 1'b0, 4'd2, 4'd0);
    repeat (20) tick();
    ack_pulse();
    chk("t2_after_ack", {GNT_M, PEND_M, PEND_C}, 3'b001);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_gap_gnt_c", GNT_C, 0);
    end
    cycles(4);
    chk("t2_country_served", {GNT_M, GNT_C}, 2'b01);

    // 3: busy load, BUSY toggled mid-walk, BCD borrow
    ready_pulse(1'b1, 1'b1, 4'd1, 4'd0);
    chk("t3_busy_load", {WALK_H, WALK_L}, 8'h10);
    tick();
    chk("t3_borrow_09", {WALK_H, WALK_L}, 8'h09);
    BUSY = 1'b1;
    tick();
    chk("t3_busy_toggle_08", {WALK_H, WALK_L}, 8'h08);
    BUSY = 1'b0;
    repeat (7) tick();
    chk("t3_count_01", {WALK_H, WALK_L}, 8'h01);
    tick();
    chk("t3_walk_off", WALK, 0);
    ack_pulse();
    chk("t3_after_ack", {GNT_C, PEND_C}, 0);

    // 4: short glitch rejected; re-press of served side ignored
    press(1'b0, 1'b1, 10);
    cycles(40);
    chk("t4_glitch_no_pend", PEND_C, 0);
    repeat (5) tick();
    cycles(4);
    chk("t4_idle_no_grant", {GNT_M, GNT_C}, 0);
    press(1'b1, 1'b0, 40);
    chk("t4_gnt_m", GNT_M, 1);
    ready_pulse(1'b0, 1'b0, 4'd2, 4'd0);
    cycles(30);
    press(1'b1, 1'b0, 40);
    cycles(30);
    chk("t4_walk_during_repress", WALK, 1);
    repeat (20) tick();
    ack_pulse();
    chk("t4_pend_m_cleared", PEND_M, 0);
    repeat (5) tick();
    cycles(10);
    chk("t4_no_second_grant", {GNT_M, GNT_C, PEND_M}, 0);

    // 5: reset mid-walk, then tie resolves with LAST=C
    press(1'b1, 1'b0, 40);
    ready_pulse(1'b0, 1'b0, 4'd2, 4'd0);
    repeat (7) tick();
    chk("t5_count_13", {WALK_H, WALK_L}, 8'h13);
    RST = 1'b1;
    #1;
    chk("t5_async_reset", {GNT_M, GNT_C, WALK, PEND_M, PEND_C, FAULT, WALK_H, WALK_L}, 0);
    cycles(2);
    RST = 1'b0;
    cycles(1);
    press(1'b1, 1'b1, 40);
    chk("t5_main_wins_after_reset", {GNT_M, GNT_C}, 2'b10);
    ready_pulse(1'b0, 1'b0, 4'd2, 4'd0);
    repeat (20) tick();
    ack_pulse();
    chk("t5_after_ack", {GNT_M, PEND_M, PEND_C}, 3'b001);
    repeat (5) tick();
    cycles(4);
    chk("t5_country_next", GNT_C, 1);

    // 6: ack withheld in RELEASE
    ready_pulse(1'b0, 1'b1, 4'd2, 4'd0);
    repeat (20) tick();
    chk("t6_in_release", {WALK, GNT_C}, 2'b01);
    repeat (7) tick();
    chk("t6_hold_7_ticks", {GNT_C, FAULT}, 2'b10);
    tick();
`ifdef ACK_TIMEOUT_EN
    chk("t6_fault_set", FAULT, 1);
    chk("t6_grant_dropped", {GNT_C, PEND_C}, 0);
    repeat (5) tick();
    chk("t6_fault_sticky", FAULT, 1);
`else
    chk("t6_no_fault", FAULT, 0);
    chk("t6_grant_holds", GNT_C, 1);
    repeat (20) tick();
    chk("t6_grant_still_holds", {GNT_C, FAULT}, 2'b10);
`endif

    cycles(5);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
